countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Counts down from a loaded time to 0.0 s, in 0.1 s steps.
- Uses the same seconds/tenths output format as the stopwatch, so the same display path can show either block.
- Generates a one-cycle done pulse and a sticky expired flag at zero.
- Sits beside the stopwatch on the 50 MHz system clock; values are loaded from the calculator/keypad side.

Parameters:
- TICKS_PER_TENTH, 5000000, clock cycles per 0.1 s step (50 MHz clock); must be >= 2.
- MAX_SECONDS, 999, largest loadable seconds value; larger loads are clamped to this.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  loads load_seconds/load_tenths; highest priority.
- load_seconds  in  32  initial seconds value.
- load_tenths  in  4  initial tenths value; values above 9 are clamped to 9.
- start  in  1  starts or resumes the countdown.
- stop  in  1  pauses the countdown.
- seconds  out  32  remaining whole seconds.
- m_seconds  out  32  remaining tenths, 0..9.
- running  out  1  high in state RUN.
- expired  out  1  high in state EXPIRED.
- done  out  1  one-cycle pulse on reaching 0.0.

Behaviour:
- Reset (asynchronous, immediate):
  - seconds=0, m_seconds=0, prescaler=0, state=IDLE.
  - running=0, expired=0, done=0.
  - All outputs are registered.
- States: IDLE, RUN, PAUSE, EXPIRED. Control priority per cycle is load > stop > start.
- load (any state):
  - seconds <= min(load_seconds, MAX_SECONDS); m_seconds <= min(load_tenths, 9).
  - prescaler <= 0; state <= IDLE; done <= 0.
  - A load during RUN halts the countdown.
- start:
  - From IDLE or PAUSE, if the value is not 0.0: go to RUN.
  - From IDLE the prescaler is already 0. From PAUSE the prescaler keeps its value, so a partial tenth resumes.
  - If the value is 0.0, start is ignored and the state stays IDLE.
  - start in EXPIRED is ignored; a load is required first.
  - start in RUN has no effect.
- stop:
  - In RUN: go to PAUSE; prescaler and value freeze.
  - In any other state: no effect.
- Prescaler:
  - Advances only in RUN, counting 0..TICKS_PER_TENTH-1.
  - tick = (prescaler == TICKS_PER_TENTH-1); on tick the prescaler wraps to 0.
  - First decrement happens TICKS_PER_TENTH cycles after the edge that enters RUN.
- On tick in RUN:
  - If m_seconds > 0: m_seconds decrements by 1.
  - Else: seconds decrements by 1 and m_seconds <= 9. A borrow never occurs when seconds==0, because 0.0 is caught below.
  - If the new value is 0.0 (seconds==0 and m_seconds==1 before the tick, or seconds==1 and m_seconds==0 can't reach 0.0 in one step): state <= EXPIRED and done <= 1 on the same edge.
- done is high for exactly one cycle, then returns to 0.
- expired stays high until load or rst.
- No wrap-around and no underflow: the value never goes below 0.0.
- Simultaneous stop and tick in the same cycle: stop wins, no decrement.
- Load in the same cycle as the expiring tick: load wins, done is not pulsed.
- Reset mid-count clears everything immediately, including a pending done.

Test Plan:
- TICKS_PER_TENTH=4; rst, then load 1 s / 2 tenths, start:
  - value steps 1.2 -> 1.1 -> 1.0 -> 0.9 ... -> 0.0, one step every 4 cycles.
  - done pulses for 1 cycle when 0.0 is reached, 48 cycles after start.
  - expired=1 and running=0 afterwards.
- Load 0 s / 3 tenths, start, stop after 6 cycles (value 0.2, prescaler 2), hold 10 cycles, start:
  - value holds 0.2 while paused.
  - next decrement occurs 2 cycles after resume.
  - 0.0 is reached 6 cycles after resume, with done pulse.
- Load 5000 s / 15 tenths: seconds=999, m_seconds=9, state IDLE. Load 0 s / 0 tenths, then start: stays IDLE, running=0, done never pulses.
- Expire a countdown, then start: ignored, expired stays 1. Then load 0 s / 1 tenth, start: expired clears on load; done pulses after 4 cycles.
- Assert rst asynchronously mid-RUN at value 0.7 (between clock edges): all outputs are 0 immediately. After release, start has no effect until a load.
- Stop and tick in the same cycle: no decrement, state PAUSE. Load and the final tick in the same cycle: loaded value appears, done stays 0.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//   Counts a loaded seconds/tenths value down to 0.0 in 0.1 s steps. Output format matches
//   the stopwatch so both blocks can share a display path.
// Ports:
//   clk, rst                  system clock (rising edge), asynchronous active-high reset
//   load                      load load_seconds/load_tenths (clamped), highest priority
//   load_seconds, load_tenths initial value; seconds clamp to MAX_SECONDS, tenths clamp to 9
//   start, stop               start/resume and pause controls (priority load > stop > start)
//   seconds, m_seconds        remaining whole seconds and tenths (0..9)
//   running, expired          state RUN / state EXPIRED
//   done                      one-cycle pulse on the edge the value reaches 0.0
module countdown_timer #(
  parameter int unsigned TICKS_PER_TENTH = 5000000,
  parameter int unsigned MAX_SECONDS     = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_seconds,
  input  logic [3:0]  load_tenths,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] seconds,
  output logic [31:0] m_seconds,
  output logic        running,
  output logic        expired,
  output logic        done
);

  localparam int unsigned PW = (TICKS_PER_TENTH > 2) ? $clog2(TICKS_PER_TENTH) : 1;
  localparam logic [PW-1:0] TickLast = PW'(TICKS_PER_TENTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   sec_q, sec_d;
  logic [3:0]    ten_q, ten_d;
  logic          done_q, done_d;
  logic          running_q, expired_q;
  logic          value_zero;

  assign value_zero = (sec_q == 32'd0) && (ten_q == 4'd0);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    ten_d   = ten_q;
    done_d  = 1'b0;
    if (load) begin
      sec_d   = (load_seconds > MAX_SECONDS) ? 32'(MAX_SECONDS) : load_seconds;
      ten_d   = (load_tenths > 4'd9) ? 4'd9 : load_tenths;
      presc_d = '0;
      state_d = StIdle;
    end else if (stop && (state_q == StRun)) begin
      // Prescaler and value freeze, so a partial tenth resumes later.
      state_d = StPause;
    end else if (start && ((state_q == StIdle) || (state_q == StPause)) && !value_zero) begin
      state_d = StRun;
    end else if (state_q == StRun) begin
      if (presc_q == TickLast) begin
        presc_d = '0;
        if (ten_q != 4'd0) begin
          ten_d = ten_q - 4'd1;
        end else begin
          sec_d = sec_q - 32'd1;
          ten_d = 4'd9;
        end
        // 0.1 -> 0.0 is the only step that lands on zero; RUN never holds 0.0.
        if ((sec_q == 32'd0) && (ten_q == 4'd1)) begin
          state_d = StExpired;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      sec_q     <= '0;
      ten_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      ten_q     <= ten_d;
      done_q    <= done_d;
      // Status flags registered from the next state so they align with state_q.
      running_q <= (state_d == StRun);
      expired_q <= (state_d == StExpired);
    end
  end

  assign seconds   = sec_q;
  assign m_seconds = {28'd0, ten_q};
  assign running   = running_q;
  assign expired   = expired_q;
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int unsigned T   = 4;
  localparam int unsigned MAX = 999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] load_seconds = '0;
  logic [3:0]  load_tenths = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] seconds, m_seconds;
  logic        running, expired, done;

  countdown_timer #(
    .TICKS_PER_TENTH(T),
    .MAX_SECONDS    (MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_seconds(load_seconds),
    .load_tenths (load_tenths),
    .start       (start),
    .stop        (stop),
    .seconds     (seconds),
    .m_seconds   (m_seconds),
    .running     (running),
    .expired     (expired),
    .done        (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: remaining time as one integer count of tenths, a mode, and how many
  // cycles of the current tenth have elapsed while running.
  int unsigned m_tenths;
  int          m_mode;   // 0 idle, 1 run, 2 pause, 3 expired
  int unsigned m_phase;
  bit          m_done;

  function automatic void model_reset();
    m_tenths = 0;
    m_mode   = 0;
    m_phase  = 0;
    m_done   = 1'b0;
  endfunction

  function automatic void model_step();
    longint unsigned s;
    int unsigned     t;
    m_done = 1'b0;
    if (load) begin
      s = load_seconds;
      if (s > MAX) s = MAX;
      t = load_tenths;
      if (t > 9) t = 9;
      m_tenths = int'(s) * 10 + t;
      m_phase  = 0;
      m_mode   = 0;
    end else if (stop && m_mode == 1) begin
      m_mode = 2;
    end else if (start && (m_mode == 0 || m_mode == 2) && m_tenths > 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_phase++;
      if (m_phase == T) begin
        m_phase = 0;
        m_tenths--;
        if (m_tenths == 0) begin
          m_mode = 3;
          m_done = 1'b1;
        end
      end
    end
  endfunction

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (seconds !== 32'(m_tenths / 10) || m_seconds !== 32'(m_tenths % 10) ||
          running !== (m_mode == 1) || expired !== (m_mode == 3) || done !== m_done) begin
        fails++;
        $display("FAIL cycle_compare t=%0t: got %0d.%0d run=%b exp=%b done=%b, required %0d.%0d run=%b exp=%b done=%b",
                 $time, seconds, m_seconds, running, expired, done, m_tenths / 10,
                 m_tenths % 10, m_mode == 1, m_mode == 3, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; model advances on the same edge.
  task automatic cyc(input bit ld, input logic [31:0] ls, input logic [3:0] lt,
                     input bit st, input bit sp);
    load = ld; load_seconds = ls; load_tenths = lt; start = st; stop = sp;
    @(posedge clk);
    model_step();
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_seconds", seconds, 32'd0);
    chk("reset_tenths", m_seconds, 32'd0);
    chk("reset_flags", {29'd0, running, expired, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1.2 s countdown: 12 steps of 4 cycles, done 48 cycles after start.
    cyc(1'b1, 32'd1, 4'd2, 1'b0, 1'b0);
    chk("load_1p2_sec", seconds, 32'd1);
    chk("load_1p2_ten", m_seconds, 32'd2);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("start_running", {31'd0, running}, 32'd1);
    idle(4);
    chk("first_step_ten", m_seconds, 32'd1);
    idle(43);
    chk("before_zero_ten", m_seconds, 32'd1);
    chk("before_zero_done", {31'd0, done}, 32'd0);
    idle(1);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_expired", {31'd0, expired}, 32'd1);
    chk("zero_running", {31'd0, running}, 32'd0);
    idle(1);
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // start while expired is ignored; load clears expired.
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("exp_start_ignored", {30'd0, running, expired}, 32'd1);
    cyc(1'b1, 32'd0, 4'd1, 1'b0, 1'b0);
    chk("load_clears_exp", {31'd0, expired}, 32'd0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(3);
    chk("short_no_done", {31'd0, done}, 32'd0);
    idle(1);
    chk("short_done", {31'd0, done}, 32'd1);

    // Pause/resume keeps the partial tenth.
    cyc(1'b1, 32'd0, 4'd3, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(6);
    chk("pre_stop_ten", m_seconds, 32'd2);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    idle(10);
    chk("paused_ten", m_seconds, 32'd2);
    chk("paused_running", {31'd0, running}, 32'd0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(1);
    chk("resume_r1_ten", m_seconds, 32'd2);
    idle(1);
    chk("resume_r2_ten", m_seconds, 32'd1);
    idle(3);
    chk("resume_r5_done", {31'd0, done}, 32'd0);
    idle(1);
    chk("resume_r6_done", {31'd0, done}, 32'd1);
    chk("resume_r6_ten", m_seconds, 32'd0);

    // Clamping, and start on 0.0.
    cyc(1'b1, 32'd5000, 4'd15, 1'b0, 1'b0);
    chk("clamp_sec", seconds, 32'd999);
    chk("clamp_ten", m_seconds, 32'd9);
    cyc(1'b1, 32'd0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("zero_start_ignored", {31'd0, running}, 32'd0);
    idle(5);

    // Stop on the ticking cycle: no decrement.
    cyc(1'b1, 32'd0, 4'd2, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    chk("stop_tick_ten", m_seconds, 32'd2);
    chk("stop_tick_run", {31'd0, running}, 32'd0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(1);
    chk("stop_tick_resume", m_seconds, 32'd1);

    // Load on the expiring tick: load wins, no done.
    cyc(1'b1, 32'd0, 4'd1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(3);
    cyc(1'b1, 32'd7, 4'd5, 1'b0, 1'b0);
    chk("load_tick_sec", seconds, 32'd7);
    chk("load_tick_ten", m_seconds, 32'd5);
    chk("load_tick_flags", {30'd0, expired, done}, 32'd0);
    idle(2);

    // Asynchronous reset mid-run at 0.7.
    cyc(1'b1, 32'd0, 4'd9, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(8);
    chk("pre_rst_ten", m_seconds, 32'd7);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_ten", m_seconds, 32'd0);
    chk("async_rst_run", {31'd0, running}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("post_rst_start", {31'd0, running}, 32'd0);

    // Random control traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit          ld, st, sp;
      logic [31:0] ls;
      ld = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 4) == 0);
      sp = ($urandom_range(0, 14) == 0);
      ls = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 2));
      cyc(ld, ls, 4'($urandom_range(0, 15)), st, sp);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
